dataflow_stream_fifo: RTL and testbench

- Downstream consumer of the byte-wide registered data stream produced by the dataflow pipeline stage; that stage's `data_out` is captured here.
- Converts the free-running stream into a valid/ready interface through a DEPTH-entry synchronous FIFO, so a stalling consumer does not lose data.
- Reports occupancy and a sticky overflow flag for producer data dropped while full.

---
 rtl/dataflow_pkg.sv | 22 ++
 rtl/dataflow_fifo_mem.sv | 26 ++
 rtl/dataflow_stream_fifo.sv | 85 ++++++++
 tb/tb_dataflow_stream_fifo.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/dataflow_pkg.sv
// Shared types and helpers for the dataflow stream blocks.
// Pointer helpers take 32-bit operands so FIFOs of any depth up to 2^31 can share them.
package dataflow_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int PTR_W_MAX  = 32;

  typedef logic [DATA_WIDTH-1:0] data_t;

  // Full when the wrap bit (bit aw) differs and the address bits below it match.
  function automatic logic ptr_full(input logic [PTR_W_MAX-1:0] wr,
                                    input logic [PTR_W_MAX-1:0] rd,
                                    input int unsigned aw);
    logic [PTR_W_MAX-1:0] diff;
    logic [PTR_W_MAX-1:0] lo_mask;
    diff    = wr ^ rd;
    lo_mask = (PTR_W_MAX'(1) << aw) - PTR_W_MAX'(1);
    return diff[aw] && ((diff & lo_mask) == '0);
  endfunction

endpackage

// File: rtl/dataflow_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read port.
// Contents are intentionally not reset; the pointers in the parent decide validity.
module dataflow_fifo_mem
  import dataflow_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dataflow_stream_fifo.sv
// First-word-fall-through FIFO turning the free-running dataflow stream into valid/ready.
// Optional DATAFLOW_FIFO_WATERMARK_EN adds a high_water output (max occupancy since reset/flush).
module dataflow_stream_fifo
  import dataflow_pkg::*;
#(
  parameter  int WIDTH = DATA_WIDTH,
  parameter  int DEPTH = FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [AW:0]      count,
`ifdef DATAFLOW_FIFO_WATERMARK_EN
  output logic [AW:0]      high_water,
`endif
  output logic             overflow
);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dataflow_stream_fifo: DEPTH must be a power of two >= 2");
    end
  endgenerate

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push, pop, drop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = ptr_full(PTR_W_MAX'(wr_ptr), PTR_W_MAX'(rd_ptr), AW);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign drop      = in_valid && full;
  assign count     = wr_ptr - rd_ptr;

  // flush wins over push/pop, so the array is not written in a flush cycle either.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr   <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr   <= rd_ptr + PTR_ONE;
      if (drop) overflow <= 1'b1;
    end
  end

  dataflow_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (out_data)
  );

`ifdef DATAFLOW_FIFO_WATERMARK_EN
  // Samples the registered count, so it trails an occupancy change by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     high_water <= '0;
    else if (flush)              high_water <= '0;
    else if (count > high_water) high_water <= count;
  end
`endif

endmodule

// File: tb/tb_dataflow_stream_fifo.sv
// Directed bench for dataflow_stream_fifo: queue model compared every cycle plus literal checks.
module tb_dataflow_stream_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic             flush = 1'b0;
  logic [AW:0]      count;
  logic             overflow;
`ifdef DATAFLOW_FIFO_WATERMARK_EN
  logic [AW:0]      high_water;
`endif

  dataflow_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .flush      (flush),
    .count      (count),
`ifdef DATAFLOW_FIFO_WATERMARK_EN
    .high_water (high_water),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit armed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: plain queue of accepted words, sticky drop flag, running max of occupancy.
  logic [WIDTH-1:0] q[$];
  bit m_ovf;
  int m_hw;
  int sz;
  bit do_pop, do_push;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_ovf = 0;
      m_hw  = 0;
    end else if (flush) begin
      q.delete();
      m_ovf = 0;
      m_hw  = 0;
    end else begin
      sz      = q.size();
      do_pop  = (sz > 0) && out_ready;
      do_push = in_valid && (sz < DEPTH);
      if (in_valid && sz == DEPTH) m_ovf = 1;
      if (sz > m_hw) m_hw = sz;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (armed && !rst) begin
      chk("m_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("m_ready", 32'(in_ready),  32'(q.size() < DEPTH));
      chk("m_count", 32'(count),     32'(q.size()));
      chk("m_ovf",   32'(overflow),  32'(m_ovf));
      if (q.size() > 0) chk("m_data", 32'(out_data), 32'(q[0]));
`ifdef DATAFLOW_FIFO_WATERMARK_EN
      chk("m_hw", 32'(high_water), 32'(m_hw));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset asserted between edges must take effect without a clock.
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    chk("rst_count", 32'(count),     32'd0);
    chk("rst_ovf",   32'(overflow),  32'd0);
    #9 rst = 1'b0;
    armed = 1;
    step();

    repeat (10) step();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_count", 32'(count),     32'd0);
    chk("idle_ready", 32'(in_ready),  32'd1);

    // FWFT: word visible right after its push edge.
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    chk("fwft_valid", 32'(out_valid), 32'd1);
    chk("fwft_data",  32'(out_data),  32'hA5);
    chk("fwft_count", 32'(count),     32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("fwft_pop", 32'(count), 32'd0);

    // Fill with 17 words; the last is dropped.
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
      if (i == 15) begin
        chk("fill_count", 32'(count),    32'd16);
        chk("fill_ready", 32'(in_ready), 32'd0);
        chk("fill_ovf0",  32'(overflow), 32'd0);
      end
    end
    in_valid = 1'b0;
    chk("fill_ovf", 32'(overflow), 32'd1);
    chk("fill_hold", 32'(count), 32'd16);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", 32'(out_data), 32'(i));
      step();
    end
    out_ready = 1'b0;
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ovf", 32'(overflow), 32'd0);

    // Full with a same-cycle pop: the incoming word is still dropped.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h80 + i);
      step();
    end
    chk("full_count", 32'(count), 32'd16);
    in_data = 8'h55; out_ready = 1'b1;
    step();
    chk("fpop_count", 32'(count),    32'd15);
    chk("fpop_ovf",   32'(overflow), 32'd1);
    chk("fpop_data",  32'(out_data), 32'h81);
    in_data = 8'h56;
    step();
    chk("fpush_count", 32'(count),    32'd15);
    chk("fpush_data",  32'(out_data), 32'h82);
    in_valid = 1'b0;
    for (int k = 0; k < 40 && out_valid; k++) step();
    chk("fpop_drained", 32'(out_valid), 32'd0);

    // Steady stream: occupancy 1, head equals the word pushed on the last edge.
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_data = 8'(8'hC0 + i);
      step();
      chk("stream_count", 32'(count),    32'd1);
      chk("stream_data",  32'(out_data), 32'(8'(8'hC0 + i)));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("stream_empty", 32'(count), 32'd0);

    // Flush with 5 entries and overflow set; the concurrent push is discarded.
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h20 + i);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (11) step();
    out_ready = 1'b0;
    chk("pre_flush_count", 32'(count),    32'd5);
    chk("pre_flush_ovf",   32'(overflow), 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'hEE;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_count", 32'(count),     32'd0);
    chk("flush_ovf2",  32'(overflow),  32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    step();
    chk("flush_discard", 32'(count), 32'd0);

`ifdef DATAFLOW_FIFO_WATERMARK_EN
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h30 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("hw_five", 32'(high_water), 32'd5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("hw_flush", 32'(high_water), 32'd0);
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
